control_pipe: RTL and testbench

Carries the decoded control bundle of the RISC-V pipeline from the ID stage through the ID/EX, EX/MEM and MEM/WB registers. It consumes the control decoder's outputs and the ID-stage register indices. It detects RAW hazards, inserts bubbles, squashes on taken branches, and (optionally) generates EX-stage forwarding selects. It sits beside the datapath pipeline registers, which obey its `stall` output.

---
 rtl/control_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_control_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// control_pipe: carries the decoded RISC-V control bundle from ID through the
// ID/EX, EX/MEM and MEM/WB registers. Detects RAW hazards (stall), inserts
// bubbles, squashes on a taken branch (flush) and optionally drives EX-stage
// forwarding selects.
//
// Build option: define CTRL_PIPE_FWD_EN to include the forwarding unit. The
// stall rule then covers load-use only. Without it, forwardA/forwardB are
// tied to 00 and any in-flight writer (EX, MEM, WB) stalls a dependent reader.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   branch..regWrite, ALUOp     ID-stage decoder outputs
//   idRs1/idRs2/idRd            ID instruction register fields
//   idUseRs1/idUseRs2           ID instruction really reads rs1/rs2
//   flush                       taken branch resolved in MEM; kill younger
//   ex*  / mem* / wb*           ID/EX, EX/MEM, MEM/WB register contents
//   stall                       combinational; PC and IF/ID hold
//   forwardA/forwardB           combinational EX operand selects
//                               (00 regfile, 10 EX/MEM, 01 MEM/WB)
module control_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       branch,
  input  logic       memRead,
  input  logic       memToReg,
  input  logic       memWrite,
  input  logic       ALUSrc,
  input  logic       regWrite,
  input  logic [1:0] ALUOp,
  input  logic [4:0] idRs1,
  input  logic [4:0] idRs2,
  input  logic [4:0] idRd,
  input  logic       idUseRs1,
  input  logic       idUseRs2,
  input  logic       flush,
  output logic       exBranch,
  output logic       exMemRead,
  output logic       exMemWrite,
  output logic       exMemToReg,
  output logic       exALUSrc,
  output logic       exRegWrite,
  output logic [1:0] exALUOp,
  output logic [4:0] exRs1,
  output logic [4:0] exRs2,
  output logic [4:0] exRd,
  output logic       memBranch,
  output logic       memMemRead,
  output logic       memMemWrite,
  output logic       memMemToReg,
  output logic       memRegWrite,
  output logic [4:0] memRd,
  output logic       wbMemToReg,
  output logic       wbRegWrite,
  output logic [4:0] wbRd,
  output logic       stall,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB
);

  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALUOP_W = 2;

  typedef struct packed {
    logic               branch;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
  } idex_t;

  typedef struct packed {
    logic             branch;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic             mem_to_reg;
    logic             reg_write;
    logic [REG_W-1:0] rd;
  } memwb_t;

  idex_t  id_bundle;
  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic hazard_ex, hazard_mem, hazard_wb;
  logic stall_raw;

  // RAW match of one ID source against one in-flight destination; x0 never matches.
  function automatic logic src_hit(input logic             use_src,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rd,
                                   input logic             wr);
    return use_src && (rs != REG_W'(0)) && (rs == rd) && wr;
  endfunction

  // Pack the ID-stage decoder outputs into one bundle
  always_comb begin
    id_bundle            = '0;
    id_bundle.branch     = branch;
    id_bundle.mem_read   = memRead;
    id_bundle.mem_write  = memWrite;
    id_bundle.mem_to_reg = memToReg;
    id_bundle.alu_src    = ALUSrc;
    id_bundle.reg_write  = regWrite;
    id_bundle.alu_op     = ALUOp;
    id_bundle.rs1        = idRs1;
    id_bundle.rs2        = idRs2;
    id_bundle.rd         = idRd;
  end

  // Per-stage hazard detection against the ID instruction's sources
  always_comb begin
    hazard_ex  = src_hit(idUseRs1, idRs1, idex_q.rd,  idex_q.reg_write)  ||
                 src_hit(idUseRs2, idRs2, idex_q.rd,  idex_q.reg_write);
    hazard_mem = src_hit(idUseRs1, idRs1, exmem_q.rd, exmem_q.reg_write) ||
                 src_hit(idUseRs2, idRs2, exmem_q.rd, exmem_q.reg_write);
    hazard_wb  = src_hit(idUseRs1, idRs1, memwb_q.rd, memwb_q.reg_write) ||
                 src_hit(idUseRs2, idRs2, memwb_q.rd, memwb_q.reg_write);
  end

`ifdef CTRL_PIPE_FWD_EN
  // Forwarding covers everything except a load still in EX
  assign stall_raw = hazard_ex && idex_q.mem_read;

  // EX operand select; the younger EX/MEM result beats MEM/WB
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (memwb_q.reg_write && (memwb_q.rd != REG_W'(0)) && (memwb_q.rd == rs))
      sel = 2'b01;
    if (exmem_q.reg_write && (exmem_q.rd != REG_W'(0)) && (exmem_q.rd == rs))
      sel = 2'b10;
    return sel;
  endfunction

  assign forwardA = fwd_sel(idex_q.rs1);
  assign forwardB = fwd_sel(idex_q.rs2);
`else
  // No bypass paths: wait until the writer has left WB
  assign stall_raw = hazard_ex || hazard_mem || hazard_wb;
  assign forwardA  = 2'b00;
  assign forwardB  = 2'b00;
`endif

  // A squash makes the held ID instruction irrelevant, so flush masks stall
  assign stall = stall_raw && !flush;

  // Next-state of the three stage registers: flush > stall > advance
  always_comb begin
    idex_d  = id_bundle;
    exmem_d = '0;
    memwb_d = '0;

    exmem_d.branch     = idex_q.branch;
    exmem_d.mem_read   = idex_q.mem_read;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.mem_to_reg = idex_q.mem_to_reg;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.rd         = idex_q.rd;

    // The branch in EX/MEM retires even on flush
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.rd         = exmem_q.rd;

    if (flush) begin
      idex_d  = '0;
      exmem_d = '0;
    end else if (stall_raw) begin
      idex_d  = '0;
    end
  end

  // Stage registers; reset loads bubbles everywhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign exBranch    = idex_q.branch;
  assign exMemRead   = idex_q.mem_read;
  assign exMemWrite  = idex_q.mem_write;
  assign exMemToReg  = idex_q.mem_to_reg;
  assign exALUSrc    = idex_q.alu_src;
  assign exRegWrite  = idex_q.reg_write;
  assign exALUOp     = idex_q.alu_op;
  assign exRs1       = idex_q.rs1;
  assign exRs2       = idex_q.rs2;
  assign exRd        = idex_q.rd;

  assign memBranch   = exmem_q.branch;
  assign memMemRead  = exmem_q.mem_read;
  assign memMemWrite = exmem_q.mem_write;
  assign memMemToReg = exmem_q.mem_to_reg;
  assign memRegWrite = exmem_q.reg_write;
  assign memRd       = exmem_q.rd;

  assign wbMemToReg  = memwb_q.mem_to_reg;
  assign wbRegWrite  = memwb_q.reg_write;
  assign wbRd        = memwb_q.rd;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: directed scenarios plus random
// instruction streams compared against a queue-of-instructions model.
module tb_control_pipe;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n;
  ins_t cur;
  logic use1, use2, fl;

  logic       exBranch, exMemRead, exMemWrite, exMemToReg, exALUSrc, exRegWrite;
  logic [1:0] exALUOp;
  logic [4:0] exRs1, exRs2, exRd;
  logic       memBranch, memMemRead, memMemWrite, memMemToReg, memRegWrite;
  logic [4:0] memRd;
  logic       wbMemToReg, wbRegWrite;
  logic [4:0] wbRd;
  logic       stall;
  logic [1:0] forwardA, forwardB;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Instructions in flight, oldest last: [0]=EX, [1]=MEM, [2]=WB
  ins_t st [3];

  always #5 clk = ~clk;

  control_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .branch(cur.branch), .memRead(cur.mem_read), .memToReg(cur.mem_to_reg),
    .memWrite(cur.mem_write), .ALUSrc(cur.alu_src), .regWrite(cur.reg_write),
    .ALUOp(cur.alu_op), .idRs1(cur.rs1), .idRs2(cur.rs2), .idRd(cur.rd),
    .idUseRs1(use1), .idUseRs2(use2), .flush(fl),
    .exBranch(exBranch), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
    .exMemToReg(exMemToReg), .exALUSrc(exALUSrc), .exRegWrite(exRegWrite),
    .exALUOp(exALUOp), .exRs1(exRs1), .exRs2(exRs2), .exRd(exRd),
    .memBranch(memBranch), .memMemRead(memMemRead), .memMemWrite(memMemWrite),
    .memMemToReg(memMemToReg), .memRegWrite(memRegWrite), .memRd(memRd),
    .wbMemToReg(wbMemToReg), .wbRegWrite(wbRegWrite), .wbRd(wbRd),
    .stall(stall), .forwardA(forwardA), .forwardB(forwardB)
  );

  logic [22:0] ex_vec;
  logic [9:0]  mem_vec;
  logic [6:0]  wb_vec;
  assign ex_vec  = {exBranch, exMemRead, exMemWrite, exMemToReg, exALUSrc, exRegWrite,
                    exALUOp, exRs1, exRs2, exRd};
  assign mem_vec = {memBranch, memMemRead, memMemWrite, memMemToReg, memRegWrite, memRd};
  assign wb_vec  = {wbMemToReg, wbRegWrite, wbRd};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Does the ID instruction read a register some in-flight writer will produce?
  function automatic bit m_stall();
    bit hit;
    hit = 1'b0;
    for (int s = 0; s < 3; s++) begin
`ifdef CTRL_PIPE_FWD_EN
      if (s != 0 || !st[0].mem_read) continue;
`endif
      if (st[s].reg_write && st[s].rd != 5'd0 &&
          ((use1 && cur.rs1 == st[s].rd) || (use2 && cur.rs2 == st[s].rd)))
        hit = 1'b1;
    end
    return hit;
  endfunction

  // Youngest older writer of rs wins (MEM before WB)
  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
`ifdef CTRL_PIPE_FWD_EN
    for (int s = 1; s < 3; s++)
      if (st[s].reg_write && st[s].rd != 5'd0 && st[s].rd == rs)
        return (s == 1) ? 2'b10 : 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic check_all();
    chk("ex",    64'(ex_vec),  64'(st[0]));
    chk("mem",   64'(mem_vec), 64'({st[1].branch, st[1].mem_read, st[1].mem_write,
                                    st[1].mem_to_reg, st[1].reg_write, st[1].rd}));
    chk("wb",    64'(wb_vec),  64'({st[2].mem_to_reg, st[2].reg_write, st[2].rd}));
    chk("stall", 64'(stall),   64'(m_stall() && !fl));
    chk("fwdA",  64'(forwardA), 64'(m_fwd(st[0].rs1)));
    chk("fwdB",  64'(forwardB), 64'(m_fwd(st[0].rs2)));
  endtask

  // Check at the falling edge, then advance the model with the rising edge
  task automatic cycle();
    ins_t nxt [3];
    @(negedge clk);
    check_all();
    if (fl)            nxt = '{ins_t'(0), ins_t'(0), st[1]};
    else if (m_stall()) nxt = '{ins_t'(0), st[0], st[1]};
    else               nxt = '{cur, st[0], st[1]};
    @(posedge clk);
    #1;
    st = nxt;
  endtask

  task automatic drive(input ins_t i, input logic a, input logic b, input logic f);
    cur = i; use1 = a; use2 = b; fl = f;
  endtask

  function automatic ins_t rtype(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2);
    ins_t t = '0;
    t.reg_write = 1'b1; t.alu_op = 2'b10; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    return t;
  endfunction

  function automatic ins_t load(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t t = '0;
    t.mem_read = 1'b1; t.mem_to_reg = 1'b1; t.alu_src = 1'b1; t.reg_write = 1'b1;
    t.rd = rd; t.rs1 = rs1;
    return t;
  endfunction

  function automatic ins_t addi(input logic [4:0] rd, input logic [4:0] rs1);
    ins_t t = '0;
    t.alu_src = 1'b1; t.reg_write = 1'b1; t.rd = rd; t.rs1 = rs1;
    return t;
  endfunction

  task automatic nops(input int n);
    drive('0, 1'b0, 1'b0, 1'b0);
    repeat (n) cycle();
  endtask

  task automatic drive_random();
    ins_t t;
    t = ins_t'(23'($urandom));
    t.rs1 = 5'($urandom_range(0, 3));
    t.rs2 = 5'($urandom_range(0, 3));
    t.rd  = 5'($urandom_range(0, 3));
    drive(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) == 0));
  endtask

  task automatic check_reset_zero();
    chk("rst_ex",    64'(ex_vec),   64'(0));
    chk("rst_mem",   64'(mem_vec),  64'(0));
    chk("rst_wb",    64'(wb_vec),   64'(0));
    chk("rst_stall", 64'(stall),    64'(0));
    chk("rst_fwd",   64'({forwardA, forwardB}), 64'(0));
  endtask

  logic [6:0] prev_mem;

  initial begin
    rst_n = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) st[s] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_zero();
    rst_n = 1'b1;

`ifdef CTRL_PIPE_FWD_EN
    // Load-use: one bubble, then MEM/WB forward
    nops(3);
    drive(load(5'd5, 5'd1), 1'b1, 1'b0, 1'b0);
    cycle();
    drive(rtype(5'd6, 5'd5, 5'd1), 1'b1, 1'b1, 1'b0);
    #1 chk("lu_stall1", 64'(stall), 64'(1));
    cycle();
    #1 chk("lu_stall2", 64'(stall), 64'(0));
    chk("lu_bubble", 64'(exRegWrite), 64'(0));
    cycle();
    chk("lu_fwdA", 64'(forwardA), 64'(2'b01));

    // EX/MEM has priority over MEM/WB
    nops(3);
    drive(rtype(5'd3, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0);
    cycle();
    cycle();
    drive(rtype(5'd4, 5'd3, 5'd3), 1'b1, 1'b1, 1'b0);
    cycle();
    chk("prio_fwdA", 64'(forwardA), 64'(2'b10));
    chk("prio_fwdB", 64'(forwardB), 64'(2'b10));
`else
    // Without forwarding the reader waits while the writer is in EX, MEM, WB
    nops(3);
    drive(rtype(5'd7, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0);
    cycle();
    drive(rtype(5'd8, 5'd7, 5'd0), 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("nf_stall", 64'(stall), 64'(k < 3));
      cycle();
    end
    chk("nf_enter", 64'({exRegWrite, exRd}), 64'({1'b1, 5'd8}));
`endif

    // Flush beats a pending stall; the MEM occupant still retires
    nops(3);
    drive(load(5'd2, 5'd1), 1'b1, 1'b0, 1'b0);
    cycle();
    drive(load(5'd5, 5'd1), 1'b1, 1'b0, 1'b0);
    cycle();
    drive(rtype(5'd6, 5'd5, 5'd1), 1'b1, 1'b1, 1'b1);
    #1 chk("fl_stall", 64'(stall), 64'(0));
    prev_mem = {memMemToReg, memRegWrite, memRd};
    cycle();
    chk("fl_ex",  64'(exRegWrite),  64'(0));
    chk("fl_mem", 64'(memRegWrite), 64'(0));
    chk("fl_wb",  64'(wb_vec),      64'(prev_mem));
    chk("fl_wb_const", 64'(wb_vec), 64'({1'b1, 1'b1, 5'd2}));

    // x0 never stalls or forwards
    nops(3);
    drive(addi(5'd0, 5'd1), 1'b1, 1'b0, 1'b0);
    cycle();
    drive(rtype(5'd1, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0);
    #1 chk("x0_stall", 64'(stall), 64'(0));
    cycle();
    chk("x0_fwd", 64'({forwardA, forwardB}), 64'(0));

    // Random streams with an asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        drive_random();
        rst_n = 1'b0;
        #1 check_reset_zero();
        for (int s = 0; s < 3; s++) st[s] = '0;
        drive(rtype(5'd9, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        cycle();
        chk("rst_first", 64'({exRegWrite, exALUOp}), 64'(3'b110));
      end
      drive_random();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
